// File: rtl/iqueue_reader_pkg.sv
// rtl/iqueue_reader_pkg.sv - shared instruction-queue sizing constants and ring helper
package iqueue_reader_pkg;

  localparam int IQUEUE_DEPTH      = 16;
  localparam int COMMON_BRAM_DELAY = 2;
  localparam int COE_WIDTH         = 32;
  localparam int IQUEUE_PTR_WIDTH  = $clog2(IQUEUE_DEPTH) + 1;

  typedef logic [IQUEUE_PTR_WIDTH-1:0] iq_ptr_t;

  // Ring index advance for arrays whose size need not be a power of two.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned size);
    return (idx + 1 == size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/iqueue_skid_fifo.sv
// rtl/iqueue_skid_fifo.sv - register-array skid FIFO with sync clear for flush
module iqueue_skid_fifo
  import iqueue_reader_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int SKID_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              push,
  input  logic [DWIDTH-1:0]                 push_data,
  input  logic                              pop,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   count,
  output logic [DWIDTH-1:0]                 head
);

  localparam int IW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  logic [DWIDTH-1:0] mem [SKID_DEPTH];
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     wr_idx;

  assign head = mem[rd_idx];

  // Push into a full FIFO is safe only alongside a pop: the slot written is the head being retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= IW'(ring_next(32'(wr_idx), SKID_DEPTH));
      end
      if (pop) rd_idx <= IW'(ring_next(32'(rd_idx), SKID_DEPTH));
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/iqueue_reader.sv
// rtl/iqueue_reader.sv - instruction queue read controller; IQUEUE_READER_PERF_EN adds stall_cnt
module iqueue_reader #(
  parameter int DWIDTH            = iqueue_reader_pkg::COE_WIDTH,
  parameter int DEPTH             = iqueue_reader_pkg::IQUEUE_DEPTH,
  parameter int AWIDTH            = $clog2(DEPTH),
  parameter int COMMON_BRAM_DELAY = iqueue_reader_pkg::COMMON_BRAM_DELAY,
  parameter int SKID_DEPTH        = COMMON_BRAM_DELAY + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH:0]   wr_ptr,
  output logic [AWIDTH:0]   rd_ptr,
  output logic [AWIDTH-1:0] ram_addrb,
  input  logic [DWIDTH-1:0] ram_doutb,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst_data
`ifdef IQUEUE_READER_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  import iqueue_reader_pkg::*;

  localparam int CW = $clog2(SKID_DEPTH + 1);

  logic [COMMON_BRAM_DELAY-1:0] vpipe;
  logic [CW-1:0]                fifo_count;
  logic [CW-1:0]                inflight;
  logic                         issue;
  logic                         push;
  logic                         pop;

  // Credit counts every word already promised a FIFO slot, so a full FIFO plus a full pipe never overflows.
  assign inflight   = CW'($countones(vpipe));
  assign issue      = !flush && (rd_ptr != wr_ptr) &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(SKID_DEPTH));
  assign push       = vpipe[COMMON_BRAM_DELAY-1];
  assign inst_valid = (fifo_count != '0);
  assign pop        = inst_valid && inst_ready;
  assign ram_addrb  = rd_ptr[AWIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      vpipe  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      vpipe  <= '0;
    end else begin
      rd_ptr <= rd_ptr + (AWIDTH+1)'(issue);
      vpipe  <= (vpipe << 1) | COMMON_BRAM_DELAY'(issue);
    end
  end

  iqueue_skid_fifo #(
    .DWIDTH     (DWIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (ram_doutb),
    .pop       (pop),
    .count     (fifo_count),
    .head      (inst_data)
  );

`ifdef IQUEUE_READER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (inst_valid && !inst_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iqueue_reader.sv
// tb/tb_iqueue_reader.sv - bench for iqueue_reader with queue RAM model and word scoreboard
module tb_iqueue_reader;
  import iqueue_reader_pkg::*;

  localparam int D     = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SK    = D + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_doutb;
  logic          flush = 1'b0;
  logic          inst_valid;
  logic          inst_ready = 1'b1;
  logic [31:0]   inst_data;
`ifdef IQUEUE_READER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  iqueue_reader #(
    .DWIDTH            (32),
    .DEPTH             (DEPTH),
    .AWIDTH            (AW),
    .COMMON_BRAM_DELAY (D),
    .SKID_DEPTH        (SK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .ram_addrb  (ram_addrb),
    .ram_doutb  (ram_doutb),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data)
`ifdef IQUEUE_READER_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Two-port queue RAM: registered address plus one output stage gives D = 2.
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_r1, ram_r2;
  always_ff @(posedge clk) begin
    ram_r1 <= ram[ram_addrb];
    ram_r2 <= ram_r1;
  end
  assign ram_doutb = ram_r2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    ram[wr_ptr[AW-1:0]] = w;
    wr_ptr = wr_ptr + 1'b1;
    sb.push_back(w);
  endtask

  // Account for the handshake and flush that the coming edge will perform.
  task automatic model_step();
    logic [31:0] exp_w;
    if (inst_valid && inst_ready) begin
      if (sb.size() == 0) check("pop_without_queued_word", 1, 0);
      else begin
        exp_w = sb.pop_front();
        check("pop_data", inst_data, exp_w);
      end
    end
    if (flush) sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    inst_ready = 1'b1;
    wr_ptr = '0;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [AW:0] start;
    int          n;
    int          stall;
    logic [31:0] base;
    logic [AW:0] exp_rd;
  } scen_t;

  scen_t tbl [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, got, gaps, stalled;
    logic [31:0] held;
    logic [AW:0] issued;
    logic        pv, full;
    logic [31:0] pdata;

    tbl[0] = '{start: 5'd0,  n: 1,  stall: 0,  base: 32'h0000_00A5, exp_rd: 5'd1};
    tbl[1] = '{start: 5'd0,  n: 16, stall: 0,  base: 32'h0000_0000, exp_rd: 5'b10000};
    tbl[2] = '{start: 5'd0,  n: 8,  stall: 10, base: 32'h0000_1000, exp_rd: 5'd8};
    tbl[3] = '{start: 5'd14, n: 4,  stall: 0,  base: 32'h0000_2000, exp_rd: 5'b10010};

    do_reset();
    check("reset_rd_ptr", rd_ptr, 0);
    check("reset_inst_valid", inst_valid, 0);
    check("reset_inst_data", inst_data, 0);
`ifdef IQUEUE_READER_PERF_EN
    check("reset_stall_cnt", stall_cnt, 0);
`endif

    for (int s = 0; s < 4; s++) begin
      do_reset();
      if (tbl[s].start != '0) begin
        wr_ptr = tbl[s].start;
        flush = 1'b1;
        model_step();
        tick();
        flush = 1'b0;
        check("start_ptr", rd_ptr, tbl[s].start);
      end
      for (int i = 0; i < tbl[s].n; i++) write_word(tbl[s].base + 32'(i));
      first = -1; got = 0; gaps = 0; stalled = 0; held = '0;
      for (int c = 0; c < 200 && got < tbl[s].n; c++) begin
        if (inst_valid && first < 0) begin
          first = c;
          check("first_valid_latency", c, D + 1);
        end
        if (first >= 0 && !inst_valid) gaps++;
        inst_ready = !(tbl[s].stall > 0 && (first < 0 || stalled < tbl[s].stall));
        if (inst_valid && !inst_ready) begin
          stalled++;
          if (stalled > 1) check("stall_data_stable", inst_data, held);
          held = inst_data;
          if (stalled == tbl[s].stall) begin
            issued = rd_ptr - tbl[s].start;
            check("issues_under_stall_le_skid", issued <= SK, 1);
          end
        end
        if (inst_valid && inst_ready) got++;
        model_step();
        tick();
      end
      check("words_received", got, tbl[s].n);
      check("scoreboard_empty", sb.size(), 0);
      check("no_gaps_after_first", gaps, 0);
      check("end_rd_ptr", rd_ptr, tbl[s].exp_rd);
`ifdef IQUEUE_READER_PERF_EN
      check("stall_cnt", stall_cnt, tbl[s].stall);
`endif
    end

    // Flush two cycles after the first issue: nothing from before the flush may surface.
    do_reset();
    for (int i = 0; i < 6; i++) write_word(32'h3000 + 32'(i));
    for (int c = 0; c < 2; c++) begin model_step(); tick(); end
    flush = 1'b1;
    model_step();
    tick();
    flush = 1'b0;
    check("flush_rd_eq_wr", rd_ptr, wr_ptr);
    for (int c = 0; c < 8; c++) begin
      check("flush_no_valid", inst_valid, 0);
      model_step();
      tick();
    end
    write_word(32'h0000_00F0);
    write_word(32'h0000_00F1);
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin model_step(); tick(); end
    check("post_flush_words_drained", sb.size(), 0);

    // Asynchronous reset while words are in flight.
    do_reset();
    for (int i = 0; i < 4; i++) write_word(32'h4000 + 32'(i));
    inst_ready = 1'b0;
    for (int c = 0; c < 10 && !inst_valid; c++) begin model_step(); tick(); end
    check("pre_reset_valid", inst_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_rd_ptr", rd_ptr, 0);
    check("async_reset_addrb", ram_addrb, 0);
    check("async_reset_valid", inst_valid, 0);
    check("async_reset_data", inst_data, 0);
`ifdef IQUEUE_READER_PERF_EN
    check("async_reset_stall_cnt", stall_cnt, 0);
`endif
    wr_ptr = '0;
    sb.delete();
    inst_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic with writer full-check, random backpressure and occasional flush.
    do_reset();
    pv = 1'b0;
    pdata = '0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      full = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
      if (!full && $urandom_range(0, 9) < 6) write_word($urandom);
      if (pv) begin
        check("rand_hold_valid", inst_valid, 1);
        check("rand_hold_data", inst_data, pdata);
      end
      pv = inst_valid && !inst_ready && !flush;
      pdata = inst_data;
      model_step();
      tick();
    end
    flush = 1'b0;
    inst_ready = 1'b1;
    for (int c = 0; c < 40 && (sb.size() != 0 || inst_valid || rd_ptr != wr_ptr); c++) begin
      model_step();
      tick();
    end
    check("drain_scoreboard_empty", sb.size(), 0);
    check("drain_rd_eq_wr", rd_ptr, wr_ptr);
    check("drain_no_valid", inst_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iqueue_reader.md
# iqueue_reader

Read-side controller for the sequencer instruction queue. It drives the read port of the queue's two-port RAM and tracks that RAM's fixed `COMMON_BRAM_DELAY` read latency with an in-flight valid pipeline. Returned words land in a small skid FIFO, which presents them as a valid/ready instruction stream to the decode stage. It exchanges wrap-bit pointers with the queue writer for empty/full detection.

## Interface
Parameters:
- `DWIDTH`, `COE_WIDTH`, instruction word width
- `DEPTH`, `IQUEUE_DEPTH`, queue entries; must be a power of two
- `AWIDTH`, `$clog2(DEPTH)`, RAM address width
- `COMMON_BRAM_DELAY`, `COMMON_BRAM_DELAY`, RAM read latency in cycles; must be ≥1
- `SKID_DEPTH`, `COMMON_BRAM_DELAY+2`, skid FIFO entries; this is also the read credit limit

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `wr_ptr` in AWIDTH+1: writer pointer with wrap bit; arrives registered from the writer
- `rd_ptr` out AWIDTH+1: reader issue pointer with wrap bit; returned to the writer for full detection
- `ram_addrb` out AWIDTH: RAM read address, equal to `rd_ptr[AWIDTH-1:0]`
- `ram_doutb` in DWIDTH: RAM read data
- `flush` in 1: synchronous discard of all queued and in-flight instructions
- `inst_valid` out 1: output instruction valid
- `inst_ready` in 1: downstream ready
- `inst_data` out DWIDTH: output instruction
- `stall_cnt` out 32: backpressure cycle count; present only when `IQUEUE_READER_PERF_EN` is defined

## Operation
- Empty: `rd_ptr == wr_ptr`. The writer computes full as `wr_ptr == {~rd_ptr[AWIDTH], rd_ptr[AWIDTH-1:0]}`.
- Issue condition: `issue = !flush && (rd_ptr != wr_ptr) && (inflight + fifo_count < SKID_DEPTH)`.
  - `inflight` is the popcount of the valid pipeline.
  - `fifo_count` excludes any pop in the same cycle.
- On issue, `rd_ptr` increments by 1 (AWIDTH+1 bits). Wrap from DEPTH-1 to 0 toggles the MSB.
- Valid pipeline: a `COMMON_BRAM_DELAY`-bit shift register. Bit 0 is loaded with `issue`. When the last bit is 1, `ram_doutb` is pushed into the skid FIFO.
- Pop: `inst_valid && inst_ready`. `inst_valid = fifo_count != 0`. `inst_data` is the FIFO head and holds stable while `inst_valid && !inst_ready`.
- Simultaneous push and pop are allowed, including at `fifo_count == SKID_DEPTH`. The credit rule guarantees the FIFO never overflows.
- `flush`:
  - At the next edge, the valid pipeline and skid FIFO are cleared and `rd_ptr <= wr_ptr` (the queue is drained).
  - Data returning from the RAM afterwards is ignored because the pipeline bits are cleared.
  - No issue occurs in the flush cycle.
  - A pop in the flush cycle still completes the handshake for that word.
- Reset values: `rd_ptr=0`, `inst_valid=0`, `inst_data=0`, valid pipeline=0, `fifo_count=0`, `stall_cnt=0`. The writer must reset its `wr_ptr` to 0 as well.

## Timing
- An issue in cycle t captures the address at the edge ending t. Data is on `ram_doutb` in cycle t+D (D=`COMMON_BRAM_DELAY`) and is pushed at the edge ending t+D. `inst_valid` rises in cycle t+D+1.
- Issue-to-output latency is D+1 cycles. Steady-state throughput is 1 instruction/cycle with `inst_ready` held high.
- Empty-to-valid: a `wr_ptr` change visible in cycle t produces `inst_valid` in cycle t+D+1.
- The slot at `rd_ptr` is free to the writer from the cycle after issue.
- Backpressure: issue stops once `inflight + fifo_count` reaches `SKID_DEPTH`, and resumes the cycle after a pop. No word is lost or duplicated.

## Configuration
- `IQUEUE_READER_PERF_EN` defined: a 32-bit `stall_cnt` port is added. It increments every cycle with `inst_valid && !inst_ready`, saturates at 2^32-1, and is not cleared by `flush`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package/defines (`vp_defines.vh`): `IQUEUE_DEPTH`, `COMMON_BRAM_DELAY`, and a pointer width macro `IQUEUE_PTR_WIDTH` = `$clog2(IQUEUE_DEPTH)+1`, shared with the writer.
- One sub-module, `iqueue_skid_fifo`: synchronous FIFO, register array, parameterized `DWIDTH`/`SKID_DEPTH`, with push/pop/count/head ports and sync clear for flush.

## Test plan
Bench paired with the queue RAM, D=2, DEPTH=16, `inst_ready` high unless stated.
- Single entry: write 0xA5 at address 0, `wr_ptr` 0→1 in cycle 10 → `inst_valid` in cycle 13 with `inst_data`=0xA5, `rd_ptr`=1.
- Streaming: 16 words 0..15 written back-to-back → 16 consecutive valid cycles in order, `rd_ptr`=5'b10000 after the wrap.
- Backpressure: 8 words queued, `inst_ready` low for 10 cycles → at most 4 issues (`SKID_DEPTH`), `inst_data` stable; on release, all 8 words in order with no gaps after the first.
- Wrap: pointers start at 14, write 4 words → addresses 14, 15, 0, 1 are read and the MSB of `rd_ptr` toggles.
- Flush mid-flight: 6 words queued, flush asserted 2 cycles after the first issue → `inst_valid`=0 from the next cycle, `rd_ptr`=`wr_ptr`, no stale word ever appears.
- Reset mid-operation: `rst_n` low while words are in flight → all outputs are 0 immediately (asynchronous); with `IQUEUE_READER_PERF_EN`, `stall_cnt` counts exactly 10 in the backpressure test.
